// File: rtl/pe_sched_if.sv
// PE-side bus of pe_sched: beat addresses/control toward the array, results back.
// master = scheduler, slave = PE array.
interface pe_sched_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] neuron_addr;
  logic [ADDR_W-1:0] weight_addr;
  logic [1:0]        pe_ctl;
  logic              pe_vld_i;
  logic              pe_vld_o;
  logic [31:0]       pe_result;

  modport master (
    output neuron_addr, weight_addr, pe_ctl, pe_vld_i,
    input  pe_vld_o, pe_result
  );

  modport slave (
    input  neuron_addr, weight_addr, pe_ctl, pe_vld_i,
    output pe_vld_o, pe_result
  );
endinterface

// File: rtl/pe_sched.sv
// pe_sched: walks the instruction table, issues neuron/weight beats to the PE array and
// forwards tagged results. Define PE_SCHED_PERF_EN to add perf_cycles/perf_stall counters.
module pe_sched #(
  parameter int INST_NUM = 4,
  parameter int ADDR_W   = 16,
  parameter int ITER_W   = 8,
  localparam int IDX_W   = (INST_NUM > 1) ? $clog2(INST_NUM) : 1,
  localparam int OUT_W   = $clog2(INST_NUM + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic [IDX_W-1:0]  inst_addr,
  input  logic [ITER_W-1:0] inst_data,
  pe_sched_if.master        pe,
  output logic              res_vld,
  output logic [IDX_W-1:0]  res_idx,
  output logic [31:0]       res_data,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef PE_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stall
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [IDX_W-1:0]  inst_addr_reg;
  logic [IDX_W-1:0]  res_idx_reg;
  logic [IDX_W-1:0]  res_cnt_reg;
  logic [ITER_W-1:0] cnt_reg;
  logic [ITER_W-1:0] iter_reg;
  logic [ADDR_W-1:0] neuron_addr_reg;
  logic [ADDR_W-1:0] weight_addr_reg;
  logic [OUT_W-1:0]  out_reg, out_next;
  logic              res_vld_reg;
  logic [31:0]       res_data_reg;
  logic              done_reg;
  logic              err_reg;

  logic start_acc;
  logic last_inst;
  logic issue;
  logic last_beat;
  logic first_beat;
  logic beat_done;
  logic ret_ok;
  logic err_set;

  assign start_acc  = (state_reg == S_IDLE) && start;
  assign last_inst  = (inst_addr_reg == IDX_W'(INST_NUM - 1));
  assign issue      = (state_reg == S_RUN) && !hold;
  assign last_beat  = (iter_reg == (cnt_reg - ITER_W'(1)));
  assign first_beat = (iter_reg == '0);
  assign beat_done  = issue && last_beat;

  // A result may retire against an instruction completing in this same cycle.
  assign ret_ok  = pe.pe_vld_o && ((out_reg != '0) || beat_done);
  assign err_set = pe.pe_vld_o && (out_reg == '0) && !beat_done;

  always_comb begin
    out_next = out_reg;
    if (beat_done && !ret_ok) begin
      out_next = out_reg + OUT_W'(1);
    end else if (!beat_done && ret_ok) begin
      out_next = out_reg - OUT_W'(1);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (inst_data != '0) begin
          state_next = S_RUN;
        end else if (last_inst) begin
          state_next = S_DRAIN;
        end
      end
      S_RUN: begin
        if (beat_done) begin
          state_next = last_inst ? S_DRAIN : S_LOAD;
        end
      end
      S_DRAIN: begin
        if (out_next == '0) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    pe.pe_vld_i    = issue;
    pe.pe_ctl      = 2'b00;
    if (issue) begin
      pe.pe_ctl = {last_beat, first_beat};
    end
    pe.neuron_addr = neuron_addr_reg;
    pe.weight_addr = weight_addr_reg;
    inst_addr      = inst_addr_reg;
    busy           = (state_reg != S_IDLE);
    done           = done_reg;
    err            = err_reg;
    res_vld        = res_vld_reg;
    res_idx        = res_idx_reg;
    res_data       = res_data_reg;
  end

  // Sequencing datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_addr_reg   <= '0;
      cnt_reg         <= '0;
      iter_reg        <= '0;
      neuron_addr_reg <= '0;
      weight_addr_reg <= '0;
      out_reg         <= '0;
      done_reg        <= 1'b0;
    end else begin
      out_reg  <= out_next;
      done_reg <= (state_reg == S_DRAIN) && (out_next == '0);
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            inst_addr_reg   <= '0;
            iter_reg        <= '0;
            neuron_addr_reg <= '0;
            weight_addr_reg <= '0;
          end
        end
        S_LOAD: begin
          cnt_reg  <= inst_data;
          iter_reg <= '0;
          // Zero-count instructions are skipped without producing a beat.
          if ((inst_data == '0) && !last_inst) begin
            inst_addr_reg <= inst_addr_reg + IDX_W'(1);
          end
        end
        S_RUN: begin
          if (issue) begin
            neuron_addr_reg <= neuron_addr_reg + ADDR_W'(1);
            weight_addr_reg <= weight_addr_reg + ADDR_W'(1);
            if (last_beat) begin
              iter_reg <= '0;
              if (!last_inst) begin
                inst_addr_reg <= inst_addr_reg + IDX_W'(1);
              end
            end else begin
              iter_reg <= iter_reg + ITER_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Result forwarding and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      res_vld_reg  <= 1'b0;
      res_data_reg <= '0;
      res_idx_reg  <= '0;
      res_cnt_reg  <= '0;
      err_reg      <= 1'b0;
    end else begin
      res_vld_reg <= pe.pe_vld_o;
      err_reg     <= (err_reg && !start_acc) || err_set;
      if (start_acc) begin
        res_idx_reg <= '0;
        res_cnt_reg <= '0;
      end
      if (pe.pe_vld_o) begin
        res_data_reg <= pe.pe_result;
        res_idx_reg  <= res_cnt_reg;
        res_cnt_reg  <= res_cnt_reg + IDX_W'(1);
      end
    end
  end

`ifdef PE_SCHED_PERF_EN
  logic [31:0] perf_cycles_reg;
  logic [31:0] perf_stall_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles_reg <= '0;
      perf_stall_reg  <= '0;
    end else if (start_acc) begin
      perf_cycles_reg <= '0;
      perf_stall_reg  <= '0;
    end else begin
      if (state_reg != S_IDLE) begin
        perf_cycles_reg <= perf_cycles_reg + 32'd1;
      end
      if ((state_reg == S_RUN) && hold) begin
        perf_stall_reg <= perf_stall_reg + 32'd1;
      end
    end
  end

  assign perf_cycles = perf_cycles_reg;
  assign perf_stall  = perf_stall_reg;
`endif

endmodule

// File: tb/tb_pe_sched.sv
// Self-checking bench for pe_sched: token-queue model of the issue sequence plus a
// result/outstanding scoreboard, randomized hold/start/PE latency, directed literal pins.
module tb_pe_sched;
  localparam int INST_NUM = 4;
  localparam int ADDR_W   = 16;
  localparam int ITER_W   = 8;
  localparam int IDX_W    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              hold = 1'b0;
  logic [IDX_W-1:0]  inst_addr;
  logic [ITER_W-1:0] inst_data;
  logic              res_vld;
  logic [IDX_W-1:0]  res_idx;
  logic [31:0]       res_data;
  logic              busy, done, err;
`ifdef PE_SCHED_PERF_EN
  logic [31:0]       perf_cycles, perf_stall;
`endif

  logic [ITER_W-1:0] counts [INST_NUM];

  pe_sched_if #(.ADDR_W(ADDR_W)) pe_if ();

  pe_sched #(.INST_NUM(INST_NUM), .ADDR_W(ADDR_W), .ITER_W(ITER_W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .hold(hold),
    .inst_addr(inst_addr),
    .inst_data(inst_data),
    .pe(pe_if),
    .res_vld(res_vld),
    .res_idx(res_idx),
    .res_data(res_data),
    .busy(busy),
    .done(done),
    .err(err)
`ifdef PE_SCHED_PERF_EN
    ,
    .perf_cycles(perf_cycles),
    .perf_stall(perf_stall)
`endif
  );

  assign inst_data = counts[inst_addr];

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: token per expected cycle of a run (0 = bubble, else bit0 beat, bit1 first, bit2 last)
  int          tok_q[$];
  int          pe_due[$];
  bit          run_active;
  int          m_out, m_beat, m_res_cnt, m_perf, m_stall;
  bit          m_err;
  bit          exp_busy, exp_done, exp_err, exp_res_vld;
  logic [31:0] exp_res_data;
  int          exp_res_idx;
  int          cyc = 0;
  int          rec_beats, rec_results;
  logic [31:0] rec_first, rec_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void build_tokens();
    tok_q.delete();
    for (int i = 0; i < INST_NUM; i++) begin
      int c;
      c = int'(counts[i]);
      tok_q.push_back(0);
      for (int j = 0; j < c; j++) begin
        tok_q.push_back(1 | ((j == 0) ? 2 : 0) | ((j == c - 1) ? 4 : 0));
      end
    end
  endfunction

  task automatic step(input bit st, input bit hd, input bit spur);
    bit          start_acc, beat_now, drain_now, inc, pv, ret;
    int          tok, out_new, due;
    logic [31:0] pdata;
    @(negedge clk);
    chk("busy", busy, exp_busy);
    chk("done", done, exp_done);
    chk("err", err, exp_err);
    chk("res_vld", res_vld, exp_res_vld);
    if (exp_res_vld) begin
      chk("res_data", res_data, exp_res_data);
      chk("res_idx", res_idx, exp_res_idx);
    end
    if (res_vld) begin
      rec_results++;
      $display("result idx=%0d data=%08h cycle=%0d", res_idx, res_data, cyc);
    end

    start = st;
    hold  = hd;
    pv    = spur;
    if (pe_due.size() > 0 && pe_due[0] <= cyc) begin
      pv = 1'b1;
      void'(pe_due.pop_front());
    end
    pdata = $urandom;
    pe_if.pe_vld_o  = pv;
    pe_if.pe_result = pdata;
    #1;

    tok      = (run_active && tok_q.size() > 0) ? tok_q[0] : 0;
    beat_now = run_active && (tok_q.size() > 0) && (tok != 0) && !hd;
    chk("pe_vld_i", pe_if.pe_vld_i, beat_now);
    if (beat_now) begin
      chk("neuron_addr", pe_if.neuron_addr, m_beat % 65536);
      chk("weight_addr", pe_if.weight_addr, m_beat % 65536);
      chk("pe_ctl", pe_if.pe_ctl, (tok >> 1) & 3);
      if (m_beat < 32) begin
        rec_first[m_beat] = pe_if.pe_ctl[0];
        rec_last[m_beat]  = pe_if.pe_ctl[1];
      end
    end else begin
      chk("pe_ctl_quiet", pe_if.pe_ctl, 0);
    end
    if (pe_if.pe_vld_i) rec_beats++;

    start_acc = st && !run_active;
    inc       = 1'b0;
    drain_now = 1'b0;
    if (run_active) begin
      m_perf++;
      if (tok_q.size() == 0) begin
        drain_now = 1'b1;
      end else if (tok == 0) begin
        void'(tok_q.pop_front());
      end else if (hd) begin
        m_stall++;
      end else begin
        if ((tok & 4) != 0) begin
          inc = 1'b1;
          due = cyc + int'($urandom_range(1, 4));
          if (pe_due.size() > 0 && due <= pe_due[$]) due = pe_due[$] + 1;
          pe_due.push_back(due);
        end
        void'(tok_q.pop_front());
        m_beat++;
      end
    end
    if (start_acc) begin
      m_err = 1'b0; m_res_cnt = 0; m_beat = 0; m_perf = 0; m_stall = 0;
    end
    ret = pv && (m_out > 0 || inc);
    if (pv && !ret) m_err = 1'b1;
    out_new      = m_out + (inc ? 1 : 0) - (ret ? 1 : 0);
    exp_res_vld  = pv;
    exp_res_data = pdata;
    exp_res_idx  = m_res_cnt % INST_NUM;
    if (pv) m_res_cnt++;
    exp_done = drain_now && (out_new == 0);
    if (exp_done) run_active = 1'b0;
    m_out = out_new;
    if (start_acc) begin
      run_active = 1'b1;
      build_tokens();
    end
    exp_busy = run_active;
    exp_err  = m_err;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; hold = 1'b0;
    pe_if.pe_vld_o = 1'b0; pe_if.pe_result = '0;
    @(negedge clk);
    rst = 1'b0;
    run_active = 1'b0; tok_q.delete(); pe_due.delete();
    m_out = 0; m_err = 1'b0; m_beat = 0; m_res_cnt = 0; m_perf = 0; m_stall = 0;
    exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_res_vld = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_res_vld", res_vld, 0);
    chk("rst_res_idx", res_idx, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_inst_addr", inst_addr, 0);
    chk("rst_neuron_addr", pe_if.neuron_addr, 0);
    chk("rst_weight_addr", pe_if.weight_addr, 0);
    chk("rst_pe_vld_i", pe_if.pe_vld_i, 0);
    chk("rst_pe_ctl", pe_if.pe_ctl, 0);
  endtask

  task automatic run_seq(input int hold_lo, input int hold_hi, input int restart_at, input bit rnd);
    int k;
    bit hd, st;
    rec_beats = 0; rec_results = 0; rec_first = '0; rec_last = '0;
    step(1'b1, 1'b0, 1'b0);
    k = 1;
    while (run_active && k < 2000) begin
      hd = (k >= hold_lo && k <= hold_hi) || (rnd && $urandom_range(0, 3) == 0);
      st = (k == restart_at) || (rnd && $urandom_range(0, 15) == 0);
      step(st, hd, 1'b0);
      k++;
    end
    chk("run_within_budget", (k < 2000), 1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    $display("run done: beats=%0d results=%0d cycle=%0d", rec_beats, rec_results, cyc);
  endtask

  initial begin
    int guard;
    pe_if.pe_vld_o  = 1'b0;
    pe_if.pe_result = '0;
    counts = '{8'd0, 8'd0, 8'd0, 8'd0};
    do_reset();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // {3,2,4,1}: 10 beats, 4 results
    counts = '{8'd3, 8'd2, 8'd4, 8'd1};
    run_seq(-1, -1, -1, 1'b0);
    chk("t1_beats", rec_beats, 10);
    chk("t1_first", rec_first, 32'h229);
    chk("t1_last", rec_last, 32'h314);
    chk("t1_results", rec_results, 4);

    // {2,0,3,1}: instruction 1 skipped
    counts = '{8'd2, 8'd0, 8'd3, 8'd1};
    run_seq(-1, -1, -1, 1'b0);
    chk("t2_beats", rec_beats, 6);
    chk("t2_first", rec_first, 32'h25);
    chk("t2_last", rec_last, 32'h32);
    chk("t2_results", rec_results, 3);

    // 5-cycle hold inside instruction 2, plus an ignored start while running
    counts = '{8'd3, 8'd2, 8'd4, 8'd1};
    run_seq(10, 14, 7, 1'b0);
    chk("t3_beats", rec_beats, 10);
    chk("t3_first", rec_first, 32'h229);
    chk("t3_last", rec_last, 32'h314);
`ifdef PE_SCHED_PERF_EN
    chk("t3_perf_stall", perf_stall, 5);
    chk("t3_perf_cycles", perf_cycles, m_perf);
`endif

    // Unexpected PE result while idle
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("idle_spur_err", err, 1);

    // Reset in the middle of instruction 1, then a clean rerun
    counts = '{8'd3, 8'd2, 8'd4, 8'd1};
    step(1'b1, 1'b0, 1'b0);
    guard = 0;
    while (m_beat < 4 && guard < 100) begin
      step(1'b0, 1'b0, 1'b0);
      guard++;
    end
    chk("t4_reach_beat4", m_beat, 4);
    do_reset();
    step(1'b0, 1'b0, 1'b0);
    run_seq(-1, -1, -1, 1'b0);
    chk("t4_beats", rec_beats, 10);
    chk("t4_first", rec_first, 32'h229);
    chk("t4_results", rec_results, 4);

    // All-zero table: LOAD chain straight to done
    counts = '{8'd0, 8'd0, 8'd0, 8'd0};
    run_seq(-1, -1, -1, 1'b0);
    chk("t5_beats", rec_beats, 0);
    chk("t5_results", rec_results, 0);

    // Randomized tables, hold, stray starts and PE latency
    for (int r = 0; r < 12; r++) begin
      int nres;
      nres = 0;
      for (int i = 0; i < INST_NUM; i++) begin
        counts[i] = ITER_W'($urandom_range(0, 5));
        if (counts[i] != 0) nres++;
      end
      run_seq(-1, -1, -1, 1'b1);
      chk("rnd_results", rec_results, nres);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
